// File: rtl/rast_test_sequencer.sv
// Hardware test sequencer for rasterizer benches: reset/init phasing, halt-aware
// triangle streaming, hit counting with quiet-period drain detection, and a watchdog.
//
// state    | meaning
// IDLE     | waiting for start, DUT held in reset
// RST_HOLD | DUT reset held for INIT_CYCLES
// INIT_DRV | driver init, pulse in first cycle
// INIT_BUF | zbuffer init, pulse in first cycle
// RUN      | streaming triangles while halt_RnnnnL allows
// DRAIN    | waiting for DRAIN_CYCLES hit-quiet cycles
// DONE     | sequence completed, counters held
// TIMEOUT  | watchdog fired, DUT back in reset
module rast_test_sequencer #(
  parameter int SIGFIG       = 24,
  parameter int VERTS        = 3,
  parameter int AXIS         = 3,
  parameter int COLORS       = 3,
  parameter int INIT_CYCLES  = 15,
  parameter int DRAIN_CYCLES = 15,
  parameter int TIMEOUT_W    = 32,
  parameter int CNT_W        = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [TIMEOUT_W-1:0]            timeout_cycles,
  input  logic [VERTS*AXIS*SIGFIG-1:0]    src_tri,
  input  logic [COLORS*SIGFIG-1:0]        src_color,
  input  logic                            src_valid,
  input  logic                            src_last,
  output logic                            src_ready,
  input  logic                            halt_RnnnnL,
  output logic [VERTS*AXIS*SIGFIG-1:0]    tri_R10S,
  output logic [COLORS*SIGFIG-1:0]        color_R10U,
  output logic                            validTri_R10H,
  output logic                            dut_rst,
  output logic                            init_drv,
  output logic                            init_buf,
  output logic [2:0]                      phase,
  output logic [CNT_W-1:0]                tri_count,
  output logic [CNT_W-1:0]                hit_count,
  input  logic                            hit_valid_R18H,
  output logic                            done,
  output logic                            timed_out
);

  localparam int TMR_MAX = (INIT_CYCLES > DRAIN_CYCLES) ? INIT_CYCLES : DRAIN_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX) + 1;
  localparam logic [TMR_W-1:0] INIT_LOAD  = TMR_W'(INIT_CYCLES - 1);
  localparam logic [TMR_W-1:0] DRAIN_LOAD = TMR_W'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RST_HOLD = 3'd1,
    S_INIT_DRV = 3'd2,
    S_INIT_BUF = 3'd3,
    S_RUN      = 3'd4,
    S_DRAIN    = 3'd5,
    S_DONE     = 3'd6,
    S_TIMEOUT  = 3'd7
  } state_t;

  state_t               state, state_nxt;
  logic [TMR_W-1:0]     tmr;
  logic [TIMEOUT_W-1:0] wd_cnt;
  logic [TIMEOUT_W-1:0] budget;
  logic                 wd_active, wd_fire, restart, tmr_zero, accept, quiet, in_init;

  always_comb begin
    state_nxt = state;
    wd_active = !(state inside {S_IDLE, S_DONE, S_TIMEOUT});
    wd_fire   = wd_active && (budget != '0) && (wd_cnt == budget);
    restart   = start && (state inside {S_IDLE, S_DONE, S_TIMEOUT});
    tmr_zero  = (tmr == '0);
    in_init   = state inside {S_RST_HOLD, S_INIT_DRV, S_INIT_BUF};
    // Gating with wd_fire keeps a triangle from being accepted and then dropped.
    src_ready = (state == S_RUN) && halt_RnnnnL && !wd_fire;
    accept    = src_valid && src_ready;
    quiet     = (state == S_DRAIN) && halt_RnnnnL && !hit_valid_R18H;

    case (state)
      S_IDLE, S_DONE, S_TIMEOUT: if (restart) state_nxt = S_RST_HOLD;
      S_RST_HOLD: if (tmr_zero) state_nxt = S_INIT_DRV;
      S_INIT_DRV: if (tmr_zero) state_nxt = S_INIT_BUF;
      S_INIT_BUF: if (tmr_zero) state_nxt = S_RUN;
      S_RUN:      if (accept && src_last) state_nxt = S_DRAIN;
      S_DRAIN:    if (quiet && tmr_zero) state_nxt = S_DONE;
      default:    state_nxt = S_IDLE;
    endcase
    if (wd_fire) state_nxt = S_TIMEOUT;

    dut_rst   = !(state inside {S_RUN, S_DRAIN, S_DONE});
    init_drv  = (state == S_INIT_DRV) && (tmr == INIT_LOAD);
    init_buf  = (state == S_INIT_BUF) && (tmr == INIT_LOAD);
    done      = (state == S_DONE);
    timed_out = (state == S_TIMEOUT);
    phase     = state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      tmr           <= '0;
      wd_cnt        <= '0;
      budget        <= '0;
      tri_count     <= '0;
      hit_count     <= '0;
      tri_R10S      <= '0;
      color_R10U    <= '0;
      validTri_R10H <= 1'b0;
    end else begin
      state <= state_nxt;

      // One down-counter serves both the init phases and the drain quiet window.
      if (state_nxt != state)
        tmr <= (state_nxt == S_DRAIN) ? DRAIN_LOAD : INIT_LOAD;
      else if ((state == S_DRAIN) && hit_valid_R18H)
        tmr <= DRAIN_LOAD;
      else if ((in_init || quiet) && !tmr_zero)
        tmr <= tmr - 1'b1;

      if (restart) begin
        wd_cnt    <= '0;
        budget    <= timeout_cycles;
        tri_count <= '0;
        hit_count <= '0;
      end else begin
        if (wd_active) wd_cnt <= wd_cnt + 1'b1;
        if (accept && !(&tri_count)) tri_count <= tri_count + 1'b1;
        if ((state inside {S_RUN, S_DRAIN}) && hit_valid_R18H && !(&hit_count))
          hit_count <= hit_count + 1'b1;
      end

      if (restart || (state_nxt == S_TIMEOUT)) begin
        validTri_R10H <= 1'b0;
      end else if ((state == S_RUN) && src_ready) begin
        validTri_R10H <= src_valid;
        if (src_valid) begin
          tri_R10S   <= src_tri;
          color_R10U <= src_color;
        end
      end else if ((state == S_DRAIN) && halt_RnnnnL) begin
        validTri_R10H <= 1'b0;
      end
    end
  end

endmodule

// File: doc/rast_test_sequencer.md
Name: rast_test_sequencer

Overview:
Synthesizable, parametrised test sequencer for rasterizer benches and FPGA bring-up. It generalises the bench control flow into hardware:
- reset/init phasing with programmable phase lengths;
- halt-aware triangle streaming into the DUT;
- hit counting and hit-aware drain detection;
- a cycle-budget watchdog.

It sits between a triangle source (FIFO/ROM) and the rasterizer top, and observes the rasterizer's hit output.

Parameters:
SIGFIG, 24, bits per coordinate/colour
VERTS, 3, vertices per triangle
AXIS, 3, axes per vertex
COLORS, 3, colour channels
INIT_CYCLES, 15, length of each init phase (>=1)
DRAIN_CYCLES, 15, hit-quiet cycles required to finish (>=1)
TIMEOUT_W, 32, watchdog counter width
CNT_W, 32, triangle/hit counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  begin sequence (sampled in IDLE, DONE, TIMEOUT)
timeout_cycles  in  TIMEOUT_W  cycle budget latched on start; 0 = disabled
src_tri  in  VERTS*AXIS*SIGFIG  source triangle; vertex v axis a at [(v*AXIS+a)*SIGFIG +: SIGFIG]
src_color  in  COLORS*SIGFIG  source colour, channel c at [c*SIGFIG +: SIGFIG]
src_valid  in  1  source has triangle
src_last  in  1  qualifies final triangle
src_ready  out  1  triangle accepted when src_valid&src_ready
halt_RnnnnL  in  1  DUT ready (low = halt)
tri_R10S  out  VERTS*AXIS*SIGFIG  triangle to DUT, same packing
color_R10U  out  COLORS*SIGFIG  colour to DUT
validTri_R10H  out  1  triangle valid
dut_rst  out  1  reset to DUT
init_drv  out  1  one-cycle pulse: driver init
init_buf  out  1  one-cycle pulse: zbuffer init
phase  out  3  current state encoding
tri_count  out  CNT_W  triangles issued
hit_count  out  CNT_W  hit_valid_R18H cycles seen
hit_valid_R18H  in  1  DUT hit output valid
done  out  1  sequence completed
timed_out  out  1  watchdog fired

Behaviour:
- Reset values: phase=IDLE, dut_rst=1, src_ready=0. All other outputs 0, including tri_R10S/color_R10U/validTri_R10H, init_drv/init_buf, counters, done and timed_out. A reset mid-operation returns all of these values on the next cycle.
- States and encodings: IDLE 0, RST_HOLD 1, INIT_DRV 2, INIT_BUF 3, RUN 4, DRAIN 5, DONE 6, TIMEOUT 7. dut_rst=1 in every state except RUN, DRAIN, DONE.
- Phase timing: start sampled high at edge k:
  - counters clear, timeout_cycles latched, done/timed_out cleared;
  - RST_HOLD occupies cycles k+1..k+INIT_CYCLES;
  - INIT_DRV follows for INIT_CYCLES cycles, init_drv=1 in its first cycle only;
  - INIT_BUF follows likewise, with init_buf;
  - RUN is entered at cycle k+3*INIT_CYCLES+1.
- start is ignored in RST_HOLD..DRAIN. In DONE/TIMEOUT it restarts the sequence exactly as from IDLE.
- RUN, transfer: src_ready = halt_RnnnnL. On an edge with halt_RnnnnL=1:
  - if src_valid: load tri/color into the output registers, validTri_R10H=1, tri_count+1;
  - else validTri_R10H=0.
- RUN, halt: with halt_RnnnnL=0 all DUT-side outputs hold their value. There is no loss and no duplication.
- Accepting src_last moves to DRAIN. src_ready=0 outside RUN.
- DRAIN:
  - validTri_R10H clears on the first edge with halt_RnnnnL=1;
  - quiet counter counts cycles with hit_valid_R18H=0 and halt_RnnnnL=1, and resets to 0 on any hit;
  - reaching DRAIN_CYCLES enters DONE.
- DONE: done=1, held.
- hit_count increments on hit_valid_R18H in RUN and DRAIN. tri_count and hit_count saturate at all-ones.
- Watchdog:
  - cycle counter runs from k+1 in all states except IDLE/DONE/TIMEOUT;
  - when nonzero budget B is reached (counter==B), the next state is TIMEOUT;
  - TIMEOUT: timed_out=1, validTri_R10H=0, src_ready=0, dut_rst=1;
  - timeout has priority over any same-cycle transition, including DRAIN->DONE.
- Counters remain readable in DONE/TIMEOUT until start or rst.

Test Plan:
- INIT_CYCLES=15, start at cycle 0 -> init_drv pulse at cycle 16, init_buf at 31, dut_rst falls and phase=4 at cycle 46.
- 4 triangles, src_last on 4th, halt_RnnnnL=1 -> validTri_R10H high 4 consecutive cycles with matching data, tri_count=4, phase=5.
- halt_RnnnnL low 3 cycles after 2nd triangle -> src_ready=0, outputs frozen 3 cycles, resume with 3rd triangle, tri_count=4 with no duplicates.
- DRAIN_CYCLES=15, hits 2 and 5 cycles after DRAIN entry -> done rises 15 quiet cycles after last hit, hit_count=2.
- timeout_cycles=20, INIT_CYCLES=15 -> phase=7 and timed_out=1 during INIT_DRV, done=0; then start -> counters 0, sequence restarts.
- rst asserted mid-RUN with validTri_R10H=1 -> next cycle phase=0, dut_rst=1, validTri_R10H=0, counters 0.
